// File: rtl/inst_fetch_pc_if.sv
// Fetch-control bus between the sequencer/decoder and the program-counter stage.
// The slave side is the PC stage; the master side drives start and decoded control.
interface inst_fetch_pc_if #(
    parameter int A    = 10,
    parameter int OFFW = 6,
    parameter int L    = 4,
    parameter int CW   = 16
);
    logic                   Start;
    logic [A-1:0]           StartAddr;
    logic                   Stall;
    logic                   Halt;
    logic                   Taken;
    logic                   BranchRel;
    logic                   BranchAbs;
    logic signed [OFFW-1:0] Offset;
    logic [L-1:0]           LutIdx;
    logic                   LutWe;
    logic [L-1:0]           LutWrIdx;
    logic [A-1:0]           LutWrData;
    logic [A-1:0]           ProgCtr;
    logic                   Busy;
    logic                   Done;
    logic [CW-1:0]          CycleCount;

    modport master (
        output Start, StartAddr, Stall, Halt, Taken, BranchRel, BranchAbs,
               Offset, LutIdx, LutWe, LutWrIdx, LutWrData,
        input  ProgCtr, Busy, Done, CycleCount
    );

    modport slave (
        input  Start, StartAddr, Stall, Halt, Taken, BranchRel, BranchAbs,
               Offset, LutIdx, LutWe, LutWrIdx, LutWrData,
        output ProgCtr, Busy, Done, CycleCount
    );
endinterface

// File: rtl/inst_fetch_pc.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control, relative and
// LUT-indirect branches, stall/halt handling and a saturating run-cycle counter.
module inst_fetch_pc #(
    parameter int A    = 10,
    parameter int OFFW = 6,
    parameter int L    = 4,
    parameter int CW   = 16
) (
    input logic         Clk,
    input logic         Reset,
    inst_fetch_pc_if.slave bus
);
    localparam int DEPTH = 1 << L;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [A-1:0]         lut [DEPTH];
    logic [A-1:0]         pc_next;
    logic signed [A-1:0]  off_ext;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        if (&cnt)
            return cnt;
        return cnt + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic signed [A-1:0] sign_ext(input logic signed [OFFW-1:0] off);
        return {{(A-OFFW){off[OFFW-1]}}, off};
    endfunction

    // Next-PC selection; Stall and Halt are handled in the sequential block.
    always_comb begin
        off_ext = sign_ext(bus.Offset);
        pc_next = bus.ProgCtr + {{(A-1){1'b0}}, 1'b1};
        if (bus.BranchAbs && bus.Taken)
            pc_next = lut[bus.LutIdx];
        else if (bus.BranchRel && bus.Taken)
            pc_next = bus.ProgCtr + $unsigned(off_ext);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            bus.ProgCtr    <= '0;
            bus.Busy       <= 1'b0;
            bus.Done       <= 1'b0;
            bus.CycleCount <= '0;
            for (int i = 0; i < DEPTH; i++)
                lut[i] <= '0;
        end else begin
            // The LUT port is independent of the sequencer state.
            if (bus.LutWe)
                lut[bus.LutWrIdx] <= bus.LutWrData;

            case (state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        state          <= RUN;
                        bus.ProgCtr    <= bus.StartAddr;
                        bus.CycleCount <= '0;
                        bus.Busy       <= 1'b1;
                        bus.Done       <= 1'b0;
                    end
                end
                RUN: begin
                    bus.CycleCount <= sat_inc(bus.CycleCount);
                    if (bus.Stall) begin
                        bus.ProgCtr <= bus.ProgCtr;
                    end else if (bus.Halt) begin
                        state    <= DONE;
                        bus.Busy <= 1'b0;
                        bus.Done <= 1'b1;
                    end else begin
                        bus.ProgCtr <= pc_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                    bus.Done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_pc.sv
// Directed bench for inst_fetch_pc: expected outputs are queued as each step is
// driven and popped/compared one cycle later, after the clock edge.
module tb_inst_fetch_pc;
    localparam int A    = 10;
    localparam int OFFW = 6;
    localparam int L    = 4;
    localparam int CW   = 16;

    typedef struct packed {
        logic [A-1:0]  pc;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    logic Clk;
    logic Reset;
    int   errors;
    int   checks;

    exp_t  exp_q [$];
    string tag_q [$];

    inst_fetch_pc_if #(.A(A), .OFFW(OFFW), .L(L), .CW(CW)) bus ();

    inst_fetch_pc #(.A(A), .OFFW(OFFW), .L(L), .CW(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        bus.Start     = 1'b0;
        bus.StartAddr = '0;
        bus.Stall     = 1'b0;
        bus.Halt      = 1'b0;
        bus.Taken     = 1'b0;
        bus.BranchRel = 1'b0;
        bus.BranchAbs = 1'b0;
        bus.Offset    = '0;
        bus.LutIdx    = '0;
        bus.LutWe     = 1'b0;
        bus.LutWrIdx  = '0;
        bus.LutWrData = '0;
    endtask

    // Queue the expectation for the upcoming edge, clock, then score it.
    task automatic step(input string tag, input int pc, input logic busy, input logic done, input int cnt);
        exp_t e;
        exp_t got;
        string t;
        e.pc   = A'(pc);
        e.busy = busy;
        e.done = done;
        e.cnt  = CW'(cnt);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        got = exp_q.pop_front();
        t   = tag_q.pop_front();
        chk(t, "pc",   32'(bus.ProgCtr),    32'(got.pc));
        chk(t, "busy", 32'(bus.Busy),       32'(got.busy));
        chk(t, "done", 32'(bus.Done),       32'(got.done));
        chk(t, "cnt",  32'(bus.CycleCount), 32'(got.cnt));
        clear_ctl();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_ctl();
        Reset = 1'b1;
        @(negedge Clk);
        step("reset", 0, 0, 0, 0);
        Reset = 1'b0;

        // Straight-line run from 5, then halt.
        step("idle_hold", 0, 0, 0, 0);
        bus.Start = 1'b1; bus.StartAddr = 10'd5;
        step("start5", 5, 1, 0, 0);
        step("seq6", 6, 1, 0, 1);
        step("seq7", 7, 1, 0, 2);
        step("seq8", 8, 1, 0, 3);
        bus.Halt = 1'b1;
        step("halt", 8, 0, 1, 4);
        step("done_hold", 8, 0, 1, 4);

        // Wrap at the top of the address space and negative relative branch.
        bus.Start = 1'b1; bus.StartAddr = 10'd1023;
        step("start1023", 1023, 1, 0, 0);
        step("wrap0", 0, 1, 0, 1);
        step("seq1", 1, 1, 0, 2);
        bus.BranchRel = 1'b1; bus.Taken = 1'b1; bus.Offset = 6'sb111110;
        step("rel_neg", 1023, 1, 0, 3);
        step("wrap0b", 0, 1, 0, 4);

        // Same-cycle write and read of lut[3] returns the old value.
        bus.LutWe = 1'b1; bus.LutWrIdx = 4'd3; bus.LutWrData = 10'd200;
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd3; bus.Taken = 1'b1;
        step("lut_rw_old", 0, 1, 0, 5);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd3; bus.Taken = 1'b1;
        step("abs_taken", 200, 1, 0, 6);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd3; bus.Taken = 1'b0;
        step("abs_not_taken", 201, 1, 0, 7);
        bus.BranchAbs = 1'b1; bus.BranchRel = 1'b1; bus.LutIdx = 4'd3;
        bus.Taken = 1'b1; bus.Offset = 6'sd5;
        step("abs_over_rel", 200, 1, 0, 8);

        // LUT write under stall, then stall+halt priority at PC 10.
        bus.Stall = 1'b1; bus.LutWe = 1'b1; bus.LutWrIdx = 4'd4; bus.LutWrData = 10'd10;
        step("stall_lutwr", 200, 1, 0, 9);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd4; bus.Taken = 1'b1;
        step("abs_to10", 10, 1, 0, 10);
        bus.Stall = 1'b1; bus.Halt = 1'b1;
        step("stall_halt1", 10, 1, 0, 11);
        bus.Stall = 1'b1; bus.Halt = 1'b1;
        step("stall_halt2", 10, 1, 0, 12);
        bus.Halt = 1'b1;
        step("halt10", 10, 0, 1, 13);

        // Restart from DONE, Start ignored in RUN, reset mid-run at PC 50.
        bus.Start = 1'b1; bus.StartAddr = 10'd9;
        step("restart9", 9, 1, 0, 0);
        bus.Start = 1'b1; bus.StartAddr = 10'd50;
        step("start_ignored", 10, 1, 0, 1);
        bus.LutWe = 1'b1; bus.LutWrIdx = 4'd5; bus.LutWrData = 10'd50;
        step("seq11", 11, 1, 0, 2);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd5; bus.Taken = 1'b1;
        step("abs_to50", 50, 1, 0, 3);
        Reset = 1'b1;
        bus.Start = 1'b1; bus.StartAddr = 10'd30;
        bus.LutWe = 1'b1; bus.LutWrIdx = 4'd3; bus.LutWrData = 10'd7;
        step("reset_midrun", 0, 0, 0, 0);
        Reset = 1'b0;

        // LUT contents were cleared by reset and the write under reset was dropped.
        bus.Start = 1'b1; bus.StartAddr = 10'd20;
        step("start20", 20, 1, 0, 0);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd3; bus.Taken = 1'b1;
        step("lut3_cleared", 0, 1, 0, 1);
        bus.BranchAbs = 1'b1; bus.LutIdx = 4'd5; bus.Taken = 1'b1;
        step("lut5_cleared", 0, 1, 0, 2);
        bus.BranchRel = 1'b1; bus.Taken = 1'b1; bus.Offset = 6'sd31;
        step("rel_pos", 31, 1, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_pc.md
# inst_fetch_pc

Program-counter and fetch-control stage that drives the instruction ROM's address input. It sequences execution from a start address through a Start/Done handshake. Each cycle it advances, branches (PC-relative or through a writable branch-target lookup table), stalls or halts, based on control decoded from the instruction currently addressed. It also counts executed cycles for performance reporting.

## Interface
- A, 10, PC / instruction-address width (matches ROM address width)
- OFFW, 6, width of signed relative-branch offset
- L, 4, log2 of branch-target LUT depth (16 entries)
- CW, 16, cycle-counter width

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin a program run at StartAddr (sampled in IDLE or DONE only)
- StartAddr  in  A  first instruction address of the run
- Stall  in  1  hold PC this cycle
- Halt  in  1  current instruction is a halt
- Taken  in  1  branch condition from ALU flags
- BranchRel  in  1  relative branch instruction
- BranchAbs  in  1  LUT-target branch instruction
- Offset  in  OFFW  signed relative offset (two's complement)
- LutIdx  in  L  LUT read index for BranchAbs
- LutWe  in  1  LUT write enable
- LutWrIdx  in  L  LUT write index
- LutWrData  in  A  LUT write data
- ProgCtr  out  A  registered PC; connects to ROM InstAddress
- Busy  out  1  high while in RUN
- Done  out  1  high while in DONE
- CycleCount  out  CW  RUN cycles in the current or last run

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE, ProgCtr=0, Busy=0, Done=0, CycleCount=0, all LUT entries=0.
- IDLE: ProgCtr holds. Start=1 → ProgCtr<=StartAddr, CycleCount<=0, state RUN.
- RUN: CycleCount += 1 every cycle, including stall cycles and the halt cycle; it saturates at all-ones. The next PC is chosen by strict priority:
  1. Stall → hold.
  2. Halt → hold; state DONE.
  3. BranchAbs & Taken → lut[LutIdx].
  4. BranchRel & Taken → ProgCtr + sign_ext(Offset), modulo 2^A.
  5. Otherwise → ProgCtr + 1, modulo 2^A.
- A branch with Taken=0 falls through to +1. If BranchAbs and BranchRel are both asserted, BranchAbs wins.
- Start is ignored in RUN.
- DONE: ProgCtr and CycleCount hold. Start=1 → same action as from IDLE.
- Wrap: PC 2^A−1 +1 → 0. Relative arithmetic is done at A bits; both underflow and overflow wrap.
- LUT: 2^L × A registers, written on the edge when LutWe=1, in any state and even during Stall. Reads are combinational. A read from the entry written in the same cycle returns the old value.
- Reset mid-run: next edge enters IDLE with all reset values. It overrides Start and LutWe.

## Timing
- ProgCtr is registered. The ROM is combinational, so the instruction at ProgCtr is valid in the same cycle.
- Control inputs are decoded from that instruction and sampled at the next edge. A branch takes effect on the following cycle with no bubble.
- Start sampled at edge t → ProgCtr=StartAddr and Busy=1 from t+1.
- Halt sampled at edge t → Busy=0 and Done=1 from t+1. Done stays high until Start or Reset.
- Busy and Done are never high together. Both are 0 in IDLE.
- Single-cycle fetch: one PC update per non-stalled RUN cycle.

## Test plan
- Reset, then Start with StartAddr=5, no control for 3 cycles, then Halt → ProgCtr 5,6,7,8, held. Done=1 one cycle after Halt. CycleCount=4.
- StartAddr=1023, no control → ProgCtr 1023 then 0. BranchRel, Taken=1, Offset=−2 (6'b111110) at PC 1 → PC 1023.
- Write lut[3]=200 via LutWe, run with BranchAbs, LutIdx=3, Taken=1 → next PC 200. Same with Taken=0 → PC+1. BranchAbs and BranchRel both asserted → 200.
- Stall and Halt both asserted for 2 cycles at PC 10 → PC holds at 10, state stays RUN, CycleCount +2. Then Halt alone → DONE.
- Reset asserted in RUN at PC 50 → next cycle ProgCtr=0, Busy=0, Done=0. A subsequent LUT read shows 0.
- Start asserted during RUN → ignored. Start in DONE with StartAddr=9 → RUN at 9, CycleCount restarts from 0.
